seg_scan_driver: RTL and testbench

Parametrised multiplexed 7-segment display driver. It is the successor to the fixed 4-digit scan logic in the top level. It scans DIGITS digits with a programmable dwell time and double-buffers the display value through a valid/ready load handshake, so that new values change only at frame boundaries. It also adds per-digit blinking, leading-zero suppression and a global enable. It sits between the service modules (time set, alarm, stopwatch, mini game) and the board's anode/segment pins.

---
 rtl/seg_pkg.sv | 34 +++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/seg_scan_driver.sv | 184 ++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and sizing helpers for the multiplexed 7-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}, active high.
package seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // All-ones anode pattern for the given digit count, padded to MAX_DIGITS.
  function automatic logic [MAX_DIGITS-1:0] anode_off(input int digits);
    logic [MAX_DIGITS-1:0] m;
    m = {MAX_DIGITS{1'b0}};
    for (int i = 0; i < MAX_DIGITS; i++) begin
      m[i] = (i < digits) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment decoder; codes 10..15 decode to blank.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Nibble to segment lookup.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-aligned double buffering,
// per-digit blink, leading-zero suppression and a global enable.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 8,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_suppress,
  input  logic                  enable,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  frame_tick
);

  localparam int PRE_W = cnt_w(SCAN_DIV);
  localparam int IDX_W = cnt_w(DIGITS);
  localparam int FC_W  = cnt_w(BLINK_FRAMES);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF_ALL = anode_off(DIGITS);
  localparam logic [DIGITS-1:0]     ANODE_OFF     = ANODE_OFF_ALL[DIGITS-1:0];

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FC_W-1:0]     fc_q, fc_d;
  logic                phase_q, phase_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]          seg_q, seg_d;
  logic                frame_tick_q, frame_tick_d;

  logic                term_s;
  logic                wrap_s;
  logic                accept_s;
  logic [3:0]          cur_nib_s;
  logic                cur_blink_s;
  logic                cur_zero_s;
  logic [DIGITS-1:0]   sel_s;
  logic [DIGITS-1:0]   zero_from_s;
  logic [6:0]          dec_seg_s;

  assign load_ready = !pending_q;
  assign anode      = anode_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

  // Scan counters, blink phase and the shadow/active handshake.
  always_comb begin
    term_s       = (pre_q == PRE_LAST);
    wrap_s       = term_s && (idx_q == IDX_LAST);
    accept_s     = load_valid && !pending_q;
    pre_d        = pre_q;
    idx_d        = idx_q;
    fc_d         = fc_q;
    phase_d      = phase_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_tick_d = wrap_s;

    if (term_s) begin
      pre_d = {PRE_W{1'b0}};
      idx_d = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    if (wrap_s) begin
      if (fc_q == FC_LAST) begin
        fc_d    = {FC_W{1'b0}};
        phase_d = !phase_q;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end else begin
      fc_d = fc_q;
    end

    // accept needs pending low and commit needs it high, so they never coincide
    if (accept_s) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end else if (wrap_s && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Trailing zero-run detection: zero_from_s[k] means nibbles k..DIGITS-1 are all zero.
  always_comb begin
    zero_from_s = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      logic acc;
      acc = 1'b1;
      for (int j = k; j < DIGITS; j++) begin
        acc = acc && (active_q[4*j +: 4] == 4'h0);
      end
      zero_from_s[k] = acc;
    end
  end

  // AND-OR select of everything that depends on the current digit index.
  always_comb begin
    cur_nib_s   = 4'h0;
    cur_blink_s = 1'b0;
    cur_zero_s  = 1'b0;
    sel_s       = ANODE_OFF;
    for (int k = 0; k < DIGITS; k++) begin
      logic hit;
      hit         = (idx_q == IDX_W'(k));
      cur_nib_s   = cur_nib_s | ({4{hit}} & active_q[4*k +: 4]);
      cur_blink_s = cur_blink_s | (hit & blink_mask[k]);
      cur_zero_s  = cur_zero_s | (hit & zero_from_s[k]);
      sel_s       = sel_s & ~({DIGITS{hit}} & (DIGITS'(1) << k));
    end
  end

  bcd_to_seg7 u_dec (
    .nibble (cur_nib_s),
    .seg    (dec_seg_s)
  );

  // Prioritised output function for the digit currently addressed.
  always_comb begin
    anode_d = ANODE_OFF;
    seg_d   = SEG_BLANK;
    if (!enable) begin
      anode_d = ANODE_OFF;
      seg_d   = SEG_BLANK;
    end else if (phase_q && cur_blink_s) begin
      anode_d = ANODE_OFF;
      seg_d   = SEG_BLANK;
    end else if (lz_suppress && (idx_q != IDX_W'(0)) && cur_zero_s) begin
      anode_d = ANODE_OFF;
      seg_d   = SEG_BLANK;
    end else begin
      anode_d = sel_s;
      seg_d   = dec_seg_s;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q        <= {PRE_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      fc_q         <= {FC_W{1'b0}};
      phase_q      <= 1'b0;
      active_q     <= {(4*DIGITS){1'b0}};
      shadow_q     <= {(4*DIGITS){1'b0}};
      pending_q    <= 1'b0;
      anode_q      <= ANODE_OFF;
      seg_q        <= SEG_BLANK;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      fc_q         <= fc_d;
      phase_q      <= phase_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  blink_mask;
  logic        lz_suppress;
  logic        enable;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        frame_tick;

  int checks;
  int errors;
  int e;

  seg_scan_driver #(
    .DIGITS       (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .enable      (enable),
    .anode       (anode),
    .seg         (seg),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to edge number 'target' since the last reset release, sampling #1 after it.
  task automatic tick_to(input int target);
    while (e < target) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] an_e, input logic [6:0] sg_e);
    checks++;
    assert (anode === an_e)
    else begin
      errors++;
      $error("FAIL %s anode: observed %b expected %b", tag, anode, an_e);
    end
    checks++;
    assert (seg === sg_e)
    else begin
      errors++;
      $error("FAIL %s seg: observed %b expected %b", tag, seg, sg_e);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    e           = 0;
    reset       = 1'b1;
    data_in     = 16'h0000;
    load_valid  = 1'b0;
    blink_mask  = 4'b0000;
    lz_suppress = 1'b0;
    enable      = 1'b1;

    @(posedge clk);
    #1;
    check_out("reset_out", 4'b1111, 7'b0000000);
    check_bit("reset_tick", frame_tick, 1'b0);
    check_bit("reset_ready", load_ready, 1'b1);
    reset = 1'b0;
    e     = 0;

    // Scan order, frame tick and a first load at cycle 5.
    tick_to(1);
    check_out("e1_d0", 4'b1110, 7'b0111111);
    check_bit("e1_tick", frame_tick, 1'b0);
    check_bit("e1_ready", load_ready, 1'b1);
    tick_to(4);
    check_out("e4_d0", 4'b1110, 7'b0111111);
    data_in    = 16'h1234;
    load_valid = 1'b1;
    tick_to(5);
    load_valid = 1'b0;
    check_bit("e5_ready", load_ready, 1'b0);
    check_out("e5_d1_old", 4'b1101, 7'b0111111);
    tick_to(9);
    check_out("e9_d2_old", 4'b1011, 7'b0111111);
    check_bit("e9_ready", load_ready, 1'b0);
    tick_to(13);
    check_out("e13_d3_old", 4'b0111, 7'b0111111);
    tick_to(15);
    check_bit("e15_tick", frame_tick, 1'b0);
    tick_to(16);
    check_bit("e16_tick", frame_tick, 1'b1);
    check_out("e16_d3_old", 4'b0111, 7'b0111111);
    check_bit("e16_ready", load_ready, 1'b1);
    tick_to(17);
    check_bit("e17_tick", frame_tick, 1'b0);
    check_out("e17_d0_4", 4'b1110, 7'b1100110);
    tick_to(21);
    check_out("e21_d1_3", 4'b1101, 7'b1001111);
    tick_to(25);
    check_out("e25_d2_2", 4'b1011, 7'b1011011);
    tick_to(29);
    check_out("e29_d3_1", 4'b0111, 7'b0000110);

    // Valid held across a commit: refused on the commit cycle, taken on the next.
    data_in    = 16'h9012;
    load_valid = 1'b1;
    tick_to(30);
    check_bit("e30_ready", load_ready, 1'b0);
    data_in = 16'h5678;
    tick_to(31);
    check_bit("e31_ready", load_ready, 1'b0);
    tick_to(32);
    check_bit("e32_tick", frame_tick, 1'b1);
    check_bit("e32_ready", load_ready, 1'b1);
    tick_to(33);
    load_valid = 1'b0;
    check_bit("e33_ready", load_ready, 1'b0);
    check_out("e33_d0_2", 4'b1110, 7'b1011011);
    tick_to(45);
    check_out("e45_d3_9", 4'b0111, 7'b1101111);
    tick_to(48);
    check_bit("e48_tick", frame_tick, 1'b1);
    tick_to(49);
    check_out("e49_d0_8", 4'b1110, 7'b1111111);
    tick_to(53);
    check_out("e53_d1_7", 4'b1101, 7'b0000111);
    tick_to(57);
    check_out("e57_d2_6", 4'b1011, 7'b1111101);
    tick_to(61);
    check_out("e61_d3_5", 4'b0111, 7'b1101101);

    // Blink digit 0; frames 6 and 7 are in the blank half-period.
    data_in    = 16'h1234;
    load_valid = 1'b1;
    tick_to(62);
    load_valid = 1'b0;
    blink_mask = 4'b0001;
    tick_to(65);
    check_out("e65_blink_on", 4'b1110, 7'b1100110);
    tick_to(81);
    check_out("e81_blink_on", 4'b1110, 7'b1100110);
    tick_to(97);
    check_out("e97_blink_off", 4'b1111, 7'b0000000);
    tick_to(101);
    check_out("e101_d1_kept", 4'b1101, 7'b1001111);
    tick_to(113);
    check_out("e113_blink_off", 4'b1111, 7'b0000000);
    tick_to(129);
    check_out("e129_blink_on", 4'b1110, 7'b1100110);

    // Leading-zero suppression, invalid nibble, global enable.
    blink_mask  = 4'b0000;
    lz_suppress = 1'b1;
    data_in     = 16'h0040;
    load_valid  = 1'b1;
    tick_to(130);
    load_valid = 1'b0;
    tick_to(145);
    check_out("lz_0040_d0", 4'b1110, 7'b0111111);
    tick_to(149);
    check_out("lz_0040_d1", 4'b1101, 7'b1100110);
    tick_to(153);
    check_out("lz_0040_d2", 4'b1111, 7'b0000000);
    tick_to(157);
    check_out("lz_0040_d3", 4'b1111, 7'b0000000);
    data_in    = 16'h0000;
    load_valid = 1'b1;
    tick_to(158);
    load_valid = 1'b0;
    tick_to(161);
    check_out("lz_0000_d0", 4'b1110, 7'b0111111);
    tick_to(165);
    check_out("lz_0000_d1", 4'b1111, 7'b0000000);
    data_in    = 16'h00A0;
    load_valid = 1'b1;
    tick_to(166);
    load_valid = 1'b0;
    tick_to(169);
    check_out("lz_0000_d2", 4'b1111, 7'b0000000);
    tick_to(177);
    check_out("nib_a_d0", 4'b1110, 7'b0111111);
    tick_to(181);
    check_out("nib_a_d1", 4'b1101, 7'b0000000);
    enable = 1'b0;
    tick_to(182);
    check_out("enable_off", 4'b1111, 7'b0000000);
    enable = 1'b1;
    tick_to(183);
    check_out("enable_on", 4'b1101, 7'b0000000);

    // Reset mid-frame with a load pending.
    lz_suppress = 1'b0;
    data_in     = 16'h9999;
    load_valid  = 1'b1;
    tick_to(186);
    load_valid = 1'b0;
    check_bit("pre_rst_ready", load_ready, 1'b0);
    tick_to(187);
    reset = 1'b1;
    #1;
    check_out("async_rst_out", 4'b1111, 7'b0000000);
    check_bit("async_rst_ready", load_ready, 1'b1);
    check_bit("async_rst_tick", frame_tick, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    e     = 0;
    tick_to(1);
    check_out("post_rst_d0", 4'b1110, 7'b0111111);
    check_bit("post_rst_ready", load_ready, 1'b1);
    tick_to(16);
    check_bit("post_rst_tick", frame_tick, 1'b1);
    tick_to(17);
    check_out("post_rst_f1_d0", 4'b1110, 7'b0111111);
    tick_to(21);
    check_out("post_rst_f1_d1", 4'b1101, 7'b0111111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
